// File: rtl/sram_pkg.sv
// Shared constants and the read-pipe entry type for the SRAM responder.
package sram_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam int LANE_LO     = 0;
  localparam int LANE_HI     = 1;

  // lane_n keeps the active-low byte enables seen at capture, {UB_N, LB_N}.
  typedef struct packed {
    logic                   valid;
    logic [SRAM_DATA_W-1:0] data;
    logic [1:0]             lane_n;
  } rd_entry_t;

  localparam rd_entry_t RD_ENTRY_IDLE = '0;

endpackage

// File: rtl/sram_rd_pipe.sv
// RD_LAT-stage shift register of read entries; advances every cycle, cleared by rst.
module sram_rd_pipe
  import sram_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  rd_entry_t in_entry,
  output rd_entry_t out_entry
);

  rd_entry_t stage [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) stage[i] <= RD_ENTRY_IDLE;
    end else begin
      stage[0] <= in_entry;
      for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign out_entry = stage[RD_LAT-1];

endmodule

// File: rtl/sram_responder.sv
// Clocked responder for the 256Kx16 async SRAM pins: byte-masked writes, pipelined
// reads with fixed latency, saturating access counters and a sticky contention flag.
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int DATA_W     = SRAM_DATA_W,
  parameter int DEPTH_LOG2 = 12,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic [ADDR_W-1:0] SRAM_adr,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  output logic              dq_drive,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic              contention
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  unused_adr_hi;
  logic                  wr_en;
  logic                  wr_any;
  logic                  rd_cap;
  logic [1:0]            lane_drv;
  rd_entry_t             cap_entry;
  rd_entry_t             out_entry;

  // Upper address bits alias onto the modelled words.
  assign idx           = SRAM_adr[DEPTH_LOG2-1:0];
  assign unused_adr_hi = ^SRAM_adr[ADDR_W-1:DEPTH_LOG2];

  assign wr_en  = !SRAM_CE_N && !SRAM_WE_N;
  assign wr_any = wr_en && !(SRAM_UB_N && SRAM_LB_N);
  assign rd_cap = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;

  // NOTE: the array has no reset branch; contents survive rst and map onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      if (!SRAM_LB_N) mem[idx][LANE_LO*8 +: 8] <= SRAM_DQ[LANE_LO*8 +: 8];
      if (!SRAM_UB_N) mem[idx][LANE_HI*8 +: 8] <= SRAM_DQ[LANE_HI*8 +: 8];
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cap_entry = RD_ENTRY_IDLE;
    if (rd_cap) begin
      cap_entry = '{valid: 1'b1, data: mem[idx], lane_n: {SRAM_UB_N, SRAM_LB_N}};
    end
  end

  sram_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_entry  (cap_entry),
    .out_entry (out_entry)
  );

  // Drive only while the controller is still reading; otherwise the pending word is dropped.
  always_comb begin
    lane_drv = 2'b00;
    if (out_entry.valid && !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) begin
      lane_drv = ~out_entry.lane_n;
    end
  end

  assign dq_drive = |lane_drv;
  assign SRAM_DQ[LANE_LO*8 +: 8] = lane_drv[LANE_LO] ? out_entry.data[LANE_LO*8 +: 8] : 8'hzz;
  assign SRAM_DQ[LANE_HI*8 +: 8] = lane_drv[LANE_HI] ? out_entry.data[LANE_HI*8 +: 8] : 8'hzz;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count   <= '0;
      wr_count   <= '0;
      contention <= 1'b0;
    end else begin
      if (rd_cap && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (wr_any && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      if (out_entry.valid && wr_en)       contention <= 1'b1;
    end
  end

endmodule
